// File: rtl/snake_pkg.sv
// Shared snake-game definitions.
// Holds the master state machine state encoding.
package snake_pkg;

  typedef enum logic [1:0] {
    MSM_IDLE = 2'd0,
    MSM_PLAY = 2'd1,
    MSM_WIN  = 2'd2,
    MSM_LOSE = 2'd3
  } msm_e;

endpackage

// File: rtl/led_tick_gen.sv
// Animation tick prescaler: one-cycle TICK every TICK_DIV cycles.
// Ports: CLK, RESET (sync, high), CLR (sync clear), TICK (pulse).
module led_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CLR,
  output logic TICK
);

  localparam int CW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign TICK = (cnt_q == LAST);

  always_ff @(posedge CLK) begin
    if (RESET || CLR) begin
      cnt_q <= '0;
    end else if (TICK) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_status_sm.sv
// LED status driver: chaser, score bar, win flash, lose hold.
// Ports: CLK, RESET, MSM_STATE, SCORE in; LED_OUT registered out.
module led_status_sm
  import snake_pkg::*;
#(
  parameter int NUM_LEDS  = 8,
  parameter int SCORE_W   = 4,
  parameter int TICK_DIV  = 25_000_000,
  parameter int LOSE_HOLD = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [1:0]          MSM_STATE,
  input  logic [SCORE_W-1:0]  SCORE,
  output logic [NUM_LEDS-1:0] LED_OUT
);

  localparam int HW = $clog2(LOSE_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX =
    HW'(LOSE_HOLD);
  localparam logic [NUM_LEDS-1:0] ONE =
    NUM_LEDS'(1);

  function automatic logic [NUM_LEDS-1:0] bar(
    input logic [SCORE_W-1:0] s
  );
    logic [NUM_LEDS-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      b[i] = (int'(s) > i);
    end
    return b;
  endfunction

  msm_e                mode_q, mode_d;
  msm_e                msm;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [HW-1:0]       hold_inc;
  logic                mode_chg;
  logic                tick;

  assign msm      = msm_e'(MSM_STATE);
  assign mode_chg = (mode_q != msm);
  assign hold_inc = hold_q + 1'b1;
  assign LED_OUT  = led_q;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (mode_chg),
    .TICK  (tick)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_q <= MSM_IDLE;
      led_q  <= ONE;
      hold_q <= '0;
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
      hold_q <= hold_d;
    end
  end

  // A mode change swallows any tick on the same edge.
  always_comb begin
    mode_d = mode_q;
    led_d  = led_q;
    hold_d = hold_q;
    if (mode_chg) begin
      mode_d = msm;
      hold_d = '0;
      unique case (msm)
        MSM_IDLE: led_d = ONE;
        MSM_PLAY: led_d = bar(SCORE);
        MSM_WIN:  led_d = '1;
        MSM_LOSE: led_d = '1;
      endcase
    end else begin
      unique case (mode_q)
        MSM_IDLE: begin
          if (tick) begin
            led_d = {led_q[NUM_LEDS-2:0],
                     led_q[NUM_LEDS-1]};
          end
        end
        MSM_PLAY: led_d = bar(SCORE);
        MSM_WIN: begin
          if (tick) led_d = ~led_q;
        end
        MSM_LOSE: begin
          // Counter saturates at LOSE_HOLD.
          if (tick && hold_q != HOLD_MAX) begin
            hold_d = hold_inc;
            if (hold_inc == HOLD_MAX) led_d = '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_status_sm.sv
// Self-checking bench for led_status_sm.
// Closed-form reference model plus directed literal checks.
module tb_led_status_sm;

  localparam int N  = 8;
  localparam int SW = 4;
  localparam int TD = 4;
  localparam int LH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    msm = 2'd0;
  logic [SW-1:0] score = '0;
  logic [N-1:0]  led;

  int n_cmp = 0;
  int n_bad = 0;

  led_status_sm #(
    .NUM_LEDS  (N),
    .SCORE_W   (SW),
    .TICK_DIV  (TD),
    .LOSE_HOLD (LH)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .MSM_STATE (msm),
    .SCORE     (score),
    .LED_OUT   (led)
  );

  always #5 clk = ~clk;

  // Expected pattern t cycles after entering mode md.
  function automatic logic [N-1:0] pat(
    input int md, input int t, input int s
  );
    logic [N-1:0] r;
    r = '0;
    case (md)
      0: r = N'(1) << ((t / TD) % N);
      1: begin
        for (int i = 0; i < N; i++)
          r[i] = (s > i);
      end
      2: r = ((t / TD) % 2 == 0) ? '1 : '0;
      default: r = (t < LH * TD) ? '1 : '0;
    endcase
    return r;
  endfunction

  int           m_mode = 0;
  int           m_t = 0;
  bit           m_ok = 0;
  logic [N-1:0] exp_led = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0;
      m_t    = 0;
      m_ok   = 1;
    end else if (m_mode != int'(msm)) begin
      m_mode = int'(msm);
      m_t    = 0;
    end else begin
      m_t++;
    end
    exp_led = pat(m_mode, m_t, int'(score));
  end

  always @(negedge clk) begin
    if (m_ok) begin
      n_cmp++;
      if (led !== exp_led) begin
        n_bad++;
        $display("FAIL model t=%0t mode=%0d got=%h want=%h",
                 $time, m_mode, led, exp_led);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(
    input string nm, input logic [N-1:0] want
  );
    n_cmp++;
    if (led !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, led, want);
    end
  endtask

  initial begin
    rst = 1; msm = 0; score = 0;
    cyc(2);
    chk("reset_val", 8'h01);
    rst = 0;
    cyc(4);  chk("idle_4", 8'h02);
    cyc(24); chk("idle_28", 8'h80);
    cyc(4);  chk("idle_wrap", 8'h01);

    msm = 1; score = 3;
    cyc(1); chk("play_3", 8'h07);
    score = 12;
    chk("play_lat", 8'h07);
    cyc(1); chk("play_sat", 8'hFF);
    score = 0;
    cyc(1); chk("play_0", 8'h00);

    msm = 2;
    cyc(1); chk("win_entry", 8'hFF);
    cyc(3); chk("win_3", 8'hFF);
    cyc(1); chk("win_4", 8'h00);
    cyc(4); chk("win_8", 8'hFF);

    msm = 3;
    cyc(1);  chk("lose_entry", 8'hFF);
    cyc(15); chk("lose_15", 8'hFF);
    cyc(1);  chk("lose_16", 8'h00);
    cyc(40); chk("lose_hold", 8'h00);
    msm = 0;
    cyc(1);  chk("lose_idle", 8'h01);

    msm = 1; score = 5;
    cyc(1); chk("col_play", 8'h1F);
    cyc(3);
    msm = 2;
    cyc(1); chk("col_entry", 8'hFF);
    cyc(3); chk("col_3", 8'hFF);
    cyc(1); chk("col_4", 8'h00);
    cyc(2);
    rst = 1;
    cyc(1); chk("rst_mid", 8'h01);
    cyc(1); chk("rst_hold", 8'h01);
    rst = 0;
    cyc(1); chk("rst_reeval", 8'hFF);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0)
        msm = 2'($urandom_range(0, 3));
      score = SW'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    rst = 0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
